// File: rtl/bus75_row_feeder.sv
// ---------------------------------------------------------------------------
// bus75_row_feeder
//
// Producer side of the HUB75 row-writer buffer pair. Pixels arriving on the
// pix_* stream are written into a back row buffer, one bit per column in each
// of the six colour planes. When the row writer pulses write_next and the back
// row is complete, the back row moves to the front buffers (buffer_*) together
// with the brightness and the row index. The row writer shifts the front
// buffers out to the panel and pulses latch, at which point row_addr follows
// the row index of the front buffers.
//
// Pixel handshake: a pixel transfers on every rising clk edge where
// pix_valid & pix_ready are both high. pix_ready depends only on internal state
// (low while the back row is full and waiting for a swap), never on pix_valid.
// pix_data and pix_sof are only looked at on a transfer.
//
// Ports
//   clk         system clock, shared with the row writer
//   rst         asynchronous reset, active high
//   pix_data    {r0,g0,b0,r1,g1,b1} for the current column
//   pix_valid   pix_data valid
//   pix_sof     pixel is frame row 0, column 0
//   pix_ready   feeder takes the pixel this cycle
//   brt_in      brightness, captured at each swap
//   write_next  row writer request to swap the front buffers
//   latch       row writer latch pulse; row_addr follows one cycle later
//   buffer_r0..buffer_b1  front colour planes, bit c = column c
//   buffer_brt  front brightness
//   row_addr    panel row address (A..D)
//   underrun    1-cycle pulse: write_next with the back row incomplete
//   sync_err    1-cycle pulse: pix_sof taken in the middle of a row
// ---------------------------------------------------------------------------
module bus75_row_feeder #(
    parameter int WIDTH    = 64,
    parameter int ROW_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          pix_data,
    input  logic                pix_valid,
    input  logic                pix_sof,
    output logic                pix_ready,
    input  logic [7:0]          brt_in,
    input  logic                write_next,
    input  logic                latch,
    output logic [WIDTH-1:0]    buffer_r0,
    output logic [WIDTH-1:0]    buffer_g0,
    output logic [WIDTH-1:0]    buffer_b0,
    output logic [WIDTH-1:0]    buffer_r1,
    output logic [WIDTH-1:0]    buffer_g1,
    output logic [WIDTH-1:0]    buffer_b1,
    output logic [7:0]          buffer_brt,
    output logic [ROW_BITS-1:0] row_addr,
    output logic                underrun,
    output logic                sync_err
);

    localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [COL_W-1:0]    col;
    logic                back_full;
    logic [ROW_BITS-1:0] back_row;
    logic [ROW_BITS-1:0] front_row;

    logic [WIDTH-1:0] back_r0;
    logic [WIDTH-1:0] back_g0;
    logic [WIDTH-1:0] back_b0;
    logic [WIDTH-1:0] back_r1;
    logic [WIDTH-1:0] back_g1;
    logic [WIDTH-1:0] back_b1;

    logic             accept;
    logic             swap;
    logic [COL_W-1:0] store_col;
    logic             last_col;

    assign pix_ready = ~back_full;

    // A swap needs a full back row, and a full back row refuses pixels, so
    // swap and accept can never both be true in one cycle. A write_next that
    // coincides with the last pixel sees back_full still low and underruns.
    always_comb begin
        accept    = pix_valid & ~back_full;
        swap      = write_next & back_full;
        store_col = pix_sof ? '0 : col;
        last_col  = (store_col == COL_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col        <= '0;
            back_full  <= 1'b0;
            back_row   <= '0;
            front_row  <= '0;
            back_r0    <= '0;
            back_g0    <= '0;
            back_b0    <= '0;
            back_r1    <= '0;
            back_g1    <= '0;
            back_b1    <= '0;
            buffer_r0  <= '0;
            buffer_g0  <= '0;
            buffer_b0  <= '0;
            buffer_r1  <= '0;
            buffer_g1  <= '0;
            buffer_b1  <= '0;
            buffer_brt <= '0;
            row_addr   <= '0;
            underrun   <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            underrun <= write_next & ~back_full;
            sync_err <= accept & pix_sof & (col != '0);

            // front_row here is the pre-swap value, so a latch that collides
            // with a swap still addresses the row that was being shifted.
            if (latch) begin
                row_addr <= front_row;
            end

            if (swap) begin
                buffer_r0  <= back_r0;
                buffer_g0  <= back_g0;
                buffer_b0  <= back_b0;
                buffer_r1  <= back_r1;
                buffer_g1  <= back_g1;
                buffer_b1  <= back_b1;
                buffer_brt <= brt_in;
                front_row  <= back_row;
                back_full  <= 1'b0;
                back_row   <= back_row + 1'b1;
            end else if (accept) begin
                // A start-of-frame pixel restarts the row at column 0; the
                // stale columns of a partial row are overwritten as it refills.
                back_r0[store_col] <= pix_data[5];
                back_g0[store_col] <= pix_data[4];
                back_b0[store_col] <= pix_data[3];
                back_r1[store_col] <= pix_data[2];
                back_g1[store_col] <= pix_data[1];
                back_b1[store_col] <= pix_data[0];
                if (pix_sof) begin
                    back_row <= '0;
                end
                if (last_col) begin
                    col       <= '0;
                    back_full <= 1'b1;
                end else begin
                    col <= store_col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus75_row_feeder.sv
// ---------------------------------------------------------------------------
// tb_bus75_row_feeder
//
// Bench for bus75_row_feeder. A pixel-level model (arrays of 6-bit pixels for
// the back and front rows, integer column/row counters) follows the stream at
// each rising edge; a compare process checks every DUT output against it on
// each falling edge. Directed sequences additionally pin known literal values.
// ---------------------------------------------------------------------------
module tb_bus75_row_feeder;

    localparam int WIDTH    = 64;
    localparam int ROW_BITS = 4;
    localparam int NROWS    = 1 << ROW_BITS;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [5:0]          pix_data   = '0;
    logic                pix_valid  = 1'b0;
    logic                pix_sof    = 1'b0;
    logic                pix_ready;
    logic [7:0]          brt_in     = '0;
    logic                write_next = 1'b0;
    logic                latch      = 1'b0;
    logic [WIDTH-1:0]    buffer_r0, buffer_g0, buffer_b0;
    logic [WIDTH-1:0]    buffer_r1, buffer_g1, buffer_b1;
    logic [7:0]          buffer_brt;
    logic [ROW_BITS-1:0] row_addr;
    logic                underrun;
    logic                sync_err;

    bus75_row_feeder #(.WIDTH(WIDTH), .ROW_BITS(ROW_BITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .pix_ready  (pix_ready),
        .brt_in     (brt_in),
        .write_next (write_next),
        .latch      (latch),
        .buffer_r0  (buffer_r0),
        .buffer_g0  (buffer_g0),
        .buffer_b0  (buffer_b0),
        .buffer_r1  (buffer_r1),
        .buffer_g1  (buffer_g1),
        .buffer_b1  (buffer_b1),
        .buffer_brt (buffer_brt),
        .row_addr   (row_addr),
        .underrun   (underrun),
        .sync_err   (sync_err)
    );

    // ---------------- counters ----------------
    int n_vec = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [5:0] m_back[WIDTH];
    logic [5:0] m_front[WIDTH];
    int         m_col;
    bit         m_full;
    int         m_back_row;
    int         m_front_row;
    logic [7:0] m_brt;
    int         m_row_addr;
    bit         m_under;
    bit         m_sync;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < WIDTH; c++) begin
                m_back[c]  = '0;
                m_front[c] = '0;
            end
            m_col = 0; m_full = 0; m_back_row = 0; m_front_row = 0;
            m_brt = '0; m_row_addr = 0; m_under = 0; m_sync = 0;
        end else begin
            bit acc;
            acc     = pix_valid && !m_full;
            m_under = write_next && !m_full;
            m_sync  = acc && pix_sof && (m_col != 0);
            if (latch) m_row_addr = m_front_row;
            if (write_next && m_full) begin
                for (int c = 0; c < WIDTH; c++) m_front[c] = m_back[c];
                m_brt       = brt_in;
                m_front_row = m_back_row;
                m_full      = 0;
                m_back_row  = (m_back_row + 1) % NROWS;
            end else if (acc) begin
                if (pix_sof) begin
                    m_back_row = 0;
                    m_col      = 0;
                end
                m_back[m_col] = pix_data;
                m_col++;
                if (m_col == WIDTH) begin
                    m_col  = 0;
                    m_full = 1;
                end
            end
        end
    end

    // Plane b of the front row: bit c is bit b of pixel c ({r0,g0,b0,r1,g1,b1}).
    function automatic logic [WIDTH-1:0] front_plane(input int b);
        logic [WIDTH-1:0] v;
        for (int c = 0; c < WIDTH; c++) v[c] = m_front[c][b];
        return v;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (check_en && !rst) begin
            chk("buffer_r0",  buffer_r0,  front_plane(5));
            chk("buffer_g0",  buffer_g0,  front_plane(4));
            chk("buffer_b0",  buffer_b0,  front_plane(3));
            chk("buffer_r1",  buffer_r1,  front_plane(2));
            chk("buffer_g1",  buffer_g1,  front_plane(1));
            chk("buffer_b1",  buffer_b1,  front_plane(0));
            chk("buffer_brt", buffer_brt, m_brt);
            chk("row_addr",   row_addr,   m_row_addr[ROW_BITS-1:0]);
            chk("underrun",   underrun,   m_under);
            chk("sync_err",   sync_err,   m_sync);
            chk("pix_ready",  pix_ready,  !m_full);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pix(input logic [5:0] d, input logic sof);
        int guard = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sof   = sof;
        while (!pix_ready && guard < 200) begin
            step();
            guard++;
        end
        if (guard >= 200) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout @%0t: pix_ready stayed %b", $time, pix_ready);
        end
        step();
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic pulse_wn();
        write_next = 1'b1;
        step();
        write_next = 1'b0;
    endtask

    task automatic pulse_latch();
        latch = 1'b1;
        step();
        latch = 1'b0;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) send_pix(6'($urandom_range(0, 63)), 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Test 1: reset with no clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst_b1",    buffer_b1,  64'h0);
        chk("rst_r0",    buffer_r0,  64'h0);
        chk("rst_brt",   buffer_brt, 8'h00);
        chk("rst_row",   row_addr,   4'h0);
        chk("rst_ready", pix_ready,  1'b1);
        step();
        step();
        rst = 1'b0;
        check_en = 1'b1;
        step();

        // Test 2: ramp row, brightness 0x40
        brt_in = 8'h40;
        for (int c = 0; c < WIDTH; c++) send_pix(6'(c), 1'b0);
        chk("t2_ready_low", pix_ready, 1'b0);
        pulse_wn();
        chk("t2_b1",    buffer_b1,  64'hAAAA_AAAA_AAAA_AAAA);
        chk("t2_r0",    buffer_r0,  64'hFFFF_FFFF_0000_0000);
        chk("t2_g0",    buffer_g0,  64'hFFFF_0000_FFFF_0000);
        chk("t2_brt",   buffer_brt, 8'h40);
        chk("t2_ready", pix_ready,  1'b1);

        // Test 3: latch addresses follow the front row
        pulse_latch();
        chk("t3_row0", row_addr, 4'h0);
        brt_in = 8'h11;
        fill_random(WIDTH);
        pulse_wn();
        pulse_latch();
        chk("t3_row1", row_addr, 4'h1);

        // Test 4: underrun keeps front and back intact
        fill_random(10);
        pulse_wn();
        chk("t4_under_hi", underrun,   1'b1);
        chk("t4_brt_keep", buffer_brt, 8'h11);
        step();
        chk("t4_under_lo", underrun,   1'b0);
        brt_in = 8'h22;
        fill_random(WIDTH - 10);
        pulse_wn();
        chk("t4_swap_brt", buffer_brt, 8'h22);
        chk("t4_no_under", underrun,   1'b0);
        pulse_latch();
        chk("t4_row2", row_addr, 4'h2);

        // Test 5: 17 rows from a frame start, row index wraps
        for (int r = 0; r < NROWS + 1; r++) begin
            brt_in = 8'($urandom_range(0, 255));
            if (r == 0) begin
                send_pix(6'($urandom_range(0, 63)), 1'b1);
                chk("t5_sof_ok", sync_err, 1'b0);
                fill_random(WIDTH - 1);
            end else begin
                fill_random(WIDTH);
            end
            pulse_wn();
            pulse_latch();
            chk("t5_row", row_addr, 64'(r % NROWS));
        end

        // Test 6: frame start in the middle of a row
        fill_random(20);
        send_pix(6'h2D, 1'b1);
        chk("t6_sync_hi", sync_err, 1'b1);
        step();
        chk("t6_sync_lo", sync_err, 1'b0);
        for (int c = 1; c < WIDTH; c++) send_pix(6'h00, 1'b0);
        pulse_wn();
        chk("t6_b1", buffer_b1, 64'h1);
        chk("t6_r0", buffer_r0, 64'h1);
        chk("t6_g0", buffer_g0, 64'h0);
        pulse_latch();
        chk("t6_row0", row_addr, 4'h0);

        // Random traffic, including write_next/latch collisions
        for (int i = 0; i < 4000; i++) begin
            pix_valid  = ($urandom_range(0, 3) != 0);
            pix_data   = 6'($urandom_range(0, 63));
            pix_sof    = ($urandom_range(0, 149) == 0);
            write_next = ($urandom_range(0, 30) == 0);
            latch      = ($urandom_range(0, 15) == 0);
            brt_in     = 8'($urandom_range(0, 255));
            step();
        end
        pix_valid = 1'b0; pix_sof = 1'b0; write_next = 1'b0; latch = 1'b0;
        step();

        // Reset in the middle of a row
        fill_random(10);
        #2 rst = 1'b1;
        #1;
        chk("mrst_b1",    buffer_b1,  64'h0);
        chk("mrst_brt",   buffer_brt, 8'h00);
        chk("mrst_row",   row_addr,   4'h0);
        chk("mrst_ready", pix_ready,  1'b1);
        #2 rst = 1'b0;
        step();
        send_pix(6'h01, 1'b0);
        for (int c = 1; c < WIDTH; c++) send_pix(6'h00, 1'b0);
        brt_in = 8'h5A;
        pulse_wn();
        chk("mrst_col0", buffer_b1,  64'h1);
        chk("mrst_brt2", buffer_brt, 8'h5A);
        pulse_latch();
        chk("mrst_row0", row_addr, 4'h0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
